// File: rtl/instruction_loader.sv
// Byte-stream boot loader: parses SYNC/ADDR/LEN/payload/CSUM frames and
// issues one registered byte write per payload byte to the instruction memory.
module instruction_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_write_enable,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_write_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);

    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [8:0]    remain_q, remain_d;
    logic [7:0]    sum_q, sum_d;
    logic          we_q, we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          accept;

    // Handshake: a byte moves only when in_valid && in_ready are both high
    // on a rising edge; in_ready is a flop, so it never depends on in_valid.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        sum_d      = sum_q;
        we_d       = 1'b0;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (accept && in_data == SYNC_BYTE) begin
                    state_d = S_ADDR;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    addr_d  = AW'(in_data);
                    sum_d   = in_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    remain_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    sum_d    = sum_q + in_data;
                    state_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    sum_d      = sum_q + in_data;
                    we_d       = 1'b1;
                    mem_addr_d = addr_q;
                    wdata_d    = in_data;
                    addr_d     = addr_q + 1'b1;
                    remain_d   = remain_q - 9'd1;
                    if (remain_q == 9'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    sum_d   = sum_q + in_data;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                if (sum_q == 8'd0) begin
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                hold_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
            end
        endcase

        in_ready_d = (state_d != S_FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            addr_q     <= '0;
            remain_q   <= '0;
            sum_q      <= '0;
            we_q       <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            sum_q      <= sum_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign mem_write_enable = we_q;
    assign mem_address      = {{(32 - AW){1'b0}}, mem_addr_q};
    assign mem_write_data   = wdata_q;
    assign cpu_hold         = hold_q;
    assign load_done        = done_q;
    assign load_error       = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: frames are expanded into expected
// write/done/error events at send time; a monitor pops them as the DUT emits.
module tb_instruction_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;

    // Event encoding: {kind[1:0], addr[7:0], data[7:0]}; kind 1=write 2=done 3=error
    logic [17:0] exp_q[$];
    logic [7:0]  pay[256];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        err_prev = 1'b0;

    instruction_loader dut (
        .clk              (clk),
        .reset            (reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .cpu_hold         (cpu_hold),
        .load_done        (load_done),
        .load_error       (load_error)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic pop_check(input logic [1:0] kind, input logic [15:0] payload);
        logic [17:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d payload 0x%0h expected none at %0t",
                     kind, payload, $time);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(kind), 32'(e[17:16]));
            if (kind == 2'd1) check("write_addr_data", 32'(payload), 32'(e[15:0]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (mem_write_enable || load_done)
                check("write_done_overlap", 32'(mem_write_enable && load_done), 32'd0);
            if (mem_write_enable) begin
                check("addr_upper_zero", mem_address >> 8, 32'd0);
                pop_check(2'd1, {mem_address[7:0], mem_write_data});
            end
            if (load_done) pop_check(2'd2, 16'h0);
            if (load_error && !err_prev) pop_check(2'd3, 16'h0);
        end
        err_prev = load_error;
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1 at %0t", $time);
        end
        @(negedge clk);
    endtask

    // Reference model: expected writes are (start+i) mod 256 <- pay[i]; the
    // frame is good when ADDR+LEN+payload+CSUM is a multiple of 256.
    task automatic send_frame(input int start, input int n, input int csum,
                              input int gap_max, input int stall_at);
        int total;
        bit good;
        total = start + (n % 256) + csum;
        for (int i = 0; i < n; i++) total += pay[i];
        good = (total % 256) == 0;
        for (int i = 0; i < n; i++)
            exp_q.push_back({2'd1, 8'((start + i) % 256), pay[i]});
        exp_q.push_back(good ? 18'h20000 : 18'h30000);

        send_byte(8'hA5);
        check("hold_after_sync", 32'(cpu_hold), 32'd1);
        check("error_cleared_by_sync", 32'(load_error), 32'd0);
        send_byte(8'(start));
        send_byte(8'(n % 256));
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                idle(5);
                check("hold_during_stall", 32'(cpu_hold), 32'd1);
            end else if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, gap_max));
            end
            send_byte(pay[i]);
        end
        send_byte(8'(csum));
        in_valid = 1'b0;
        check("ready_low_in_finish", 32'(in_ready), 32'd0);
        idle(3);
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("error_level", 32'(load_error), 32'(!good));
        check("ready_back_in_idle", 32'(in_ready), 32'd1);
    endtask

    function automatic int good_csum(input int start, input int n);
        int total = start + (n % 256);
        for (int i = 0; i < n; i++) total += pay[i];
        return (256 - (total % 256)) % 256;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #2 reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_wdata", 32'(mem_write_data), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(load_error), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("ready_low_just_after_reset", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("ready_high_in_idle", 32'(in_ready), 32'd1);

        // Basic good frame and the same frame with a bad checksum.
        pay[0] = 8'h20; pay[1] = 8'h08; pay[2] = 8'h00; pay[3] = 8'h05;
        send_frame(8'h00, 4, 8'hCF, 0, -1);
        send_frame(8'h00, 4, 8'hCE, 0, -1);
        idle(5);
        check("error_sticky", 32'(load_error), 32'd1);

        // Address wrap 0xFE -> 0x00.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(8'hFE, 3, 8'h99, 0, -1);

        // LEN=0 means 256 bytes.
        for (int i = 0; i < 256; i++) pay[i] = 8'(i);
        send_frame(8'h00, 256, 8'h80, 0, -1);

        // Noise in IDLE, then a frame with a 5-cycle stall mid-payload.
        send_byte(8'h12);
        send_byte(8'h34);
        idle(2);
        check("noise_no_hold", 32'(cpu_hold), 32'd0);
        pay[0] = 8'hAA; pay[1] = 8'hBB;
        send_frame(8'h10, 2, good_csum(8'h10, 2), 0, 1);

        // Reset during DATA after 2 of 4 bytes.
        exp_q.push_back({2'd1, 8'h40, 8'hC1});
        exp_q.push_back({2'd1, 8'h41, 8'hC2});
        send_byte(8'hA5);
        send_byte(8'h40);
        send_byte(8'h04);
        send_byte(8'hC1);
        send_byte(8'hC2);
        idle(1);
        reset = 1'b1;
        #1;
        check("midrst_we", 32'(mem_write_enable), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_addr", mem_address, 32'd0);
        check("midrst_wdata", 32'(mem_write_data), 32'd0);
        check("midrst_done_err", 32'({load_done, load_error}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        check("post_reset_queue_drained", 32'(exp_q.size()), 32'd0);
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        send_frame(8'h40, 4, good_csum(8'h40, 4), 0, -1);

        // Randomized frames: random start, length, data, gaps, noise, checksum.
        for (int f = 0; f < 12; f++) begin
            int start, n, cs;
            start = $urandom_range(0, 255);
            n     = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom_range(0, 255));
            cs = good_csum(start, n);
            if ($urandom_range(0, 2) == 0) cs = (cs + $urandom_range(1, 255)) % 256;
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 164)));
            send_frame(start, n, cs, 3, -1);
        end

        idle(5);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
